pipe_drawer: RTL
================

// Module: pipe_drawer
// PURPOSE
// Downstream of the pipe position register: consumes the pipe's current x (left edge)
// and y (top of opening) once per game tick and rasterises it into the VGA adapter's
// pixel interface. Each request erases the previously drawn pipe column strip, then
// draws the new one: pipe colour above and below the opening, background inside it.
// Emits one pixel per CLOCK_50 cycle; busy/done let the game FSM sequence other drawers.
// PARAMETERS
// SCREEN_W     160     visible columns; pixel columns >= SCREEN_W are never plotted
// SCREEN_H     120     visible rows, scanned 0..SCREEN_H-1
// PIPE_W       4       pipe width in pixels, columns x..x+PIPE_W-1
// GAP_H        20      opening height in pixels, rows y..y+GAP_H-1
// PIPE_COLOUR  3'b010  colour of pipe body
// BG_COLOUR    3'b000  background / erase colour
// PORTS
// CLOCK_50   in   1  system clock, all state on rising edge
// reset      in   1  asynchronous, active-high reset
// pipe_x     in   8  new pipe left edge (0..SCREEN_W; SCREEN_W = fully off-screen)
// pipe_y     in   7  new pipe opening top row
// draw_req   in   1  one-cycle request to redraw pipe at pipe_x/pipe_y
// vga_x      out  8  pixel column to VGA adapter
// vga_y      out  7  pixel row to VGA adapter
// colour     out  3  pixel colour
// plot       out  1  write-enable for current vga_x/vga_y/colour
// busy       out  1  high while ERASE or DRAW in progress
// done       out  1  one-cycle pulse when redraw complete
// BEHAVIOUR
// - Reset (async, active-high): state=IDLE; vga_x=0, vga_y=0, colour=0, plot=0,
//   busy=0, done=0; old_valid=0; latched old/new positions cleared to 0.
// - States: IDLE -> ERASE -> DRAW -> DONE -> IDLE. All outputs registered.
// - IDLE: draw_req=1 at edge N latches pipe_x/pipe_y as new_x/new_y; busy=1 after N;
//   go to ERASE if old_valid else directly to DRAW. draw_req=0: hold, plot=0.
// - Scan order (ERASE and DRAW): column c=0..PIPE_W-1 outer, row r=0..SCREEN_H-1 inner;
//   exactly one pixel per cycle, PIPE_W*SCREEN_H cycles per phase. First pixel
//   on outputs after edge N+1.
// - ERASE: vga_x=old_x+c, vga_y=r, colour=BG_COLOUR.
// - DRAW: vga_x=new_x+c, vga_y=r; colour=BG_COLOUR if new_y<=r<new_y+GAP_H,
//   else PIPE_COLOUR. new_y+GAP_H computed in 8 bits (no wrap); rows beyond
//   SCREEN_H-1 simply not reached.
// - Clipping: column sum computed 9 bits; if >= SCREEN_W, plot=0 for that pixel but
//   the scan still steps (cycle count unchanged). Otherwise plot=1.
// - DONE: one cycle with plot=0, done=1, busy=0; old_x/old_y <= new_x/new_y,
//   old_valid <= 1; return to IDLE. Total latency N -> done: 2*PIPE_W*SCREEN_H+1
//   cycles with erase, PIPE_W*SCREEN_H+1 without.
// - draw_req while busy or in DONE: ignored, not queued; latched position unchanged.
// - pipe_x/pipe_y changes mid-redraw: no effect (only latched copy used).
// - Reset mid-operation: aborts immediately to reset values; old_valid=0 so next
//   request skips ERASE (screen clear is the caller's responsibility).
// TESTING
// 1 reset, draw_req x=100,y=50 -> no erase; 480 plot pulses, cols 100..103, rows
//   50..69 colour 000, other rows 010; done one cycle after last pixel (481 cycles).
// 2 then draw_req x=99,y=30 -> 480 erase pixels cols 100..103 colour 000, then 480
//   draw pixels cols 99..102, gap rows 30..49; done at cycle 961.
// 3 draw_req x=158 (after valid pipe) -> draw phase: cols 158,159 plotted (240 pulses),
//   cols 160,161 plot=0; phase still 480 cycles.
// 4 draw_req y=110 -> rows 110..119 background, rows 0..109 pipe; no wrap to row 0.
// 5 pulse draw_req again at cycle 200 of a redraw -> ignored; exactly one done pulse,
//   pixel stream unchanged.
// 6 assert reset at cycle 300 of ERASE -> plot/busy/done=0 at once; next request
//   skips ERASE and finishes in 481 cycles.

Source files
------------

// File: rtl/pipe_drawer.sv
// Rasterises one pipe column strip into the VGA adapter's pixel port: erases the
// previously drawn strip, then draws the new one, one pixel per clock.
module pipe_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int PIPE_W = 4,
  parameter int GAP_H = 20,
  parameter logic [2:0] PIPE_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] pipe_x,
  input  logic [6:0] pipe_y,
  input  logic       draw_req,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int CW = (PIPE_W > 1) ? $clog2(PIPE_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t r_state, w_next;

  // Erase always covers the full column height, so only the old column is kept.
  logic [7:0]    r_newX, r_oldX;
  logic [6:0]    r_newY;
  logic          r_oldValid;
  logic [CW-1:0] r_col;
  logic [6:0]    r_row;

  logic       w_lastPix;
  logic [7:0] w_baseX;
  logic [8:0] w_colSum;
  logic [7:0] w_gapEnd;
  logic       w_inGap;
  logic [2:0] w_pixColour;

  assign w_lastPix   = (r_col == CW'(PIPE_W - 1)) && (r_row == 7'(SCREEN_H - 1));
  assign w_baseX     = (r_state == S_ERASE) ? r_oldX : r_newX;
  assign w_colSum    = {1'b0, w_baseX} + 9'(r_col);
  assign w_gapEnd    = {1'b0, r_newY} + 8'(GAP_H);
  assign w_inGap     = (r_row >= r_newY) && ({1'b0, r_row} < w_gapEnd);
  assign w_pixColour = ((r_state == S_ERASE) || w_inGap) ? BG_COLOUR : PIPE_COLOUR;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (draw_req) w_next = r_oldValid ? S_ERASE : S_DRAW;
      S_ERASE: if (w_lastPix) w_next = S_DRAW;
      S_DRAW:  if (w_lastPix) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Column-outer, row-inner scan counter; restarts at the phase boundary.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if ((r_state == S_ERASE) || (r_state == S_DRAW)) begin
      if (w_lastPix) begin
        r_col <= '0;
        r_row <= '0;
      end else if (r_row == 7'(SCREEN_H - 1)) begin
        r_col <= r_col + 1'b1;
        r_row <= '0;
      end else begin
        r_row <= r_row + 1'b1;
      end
    end else begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_newX     <= '0;
      r_newY     <= '0;
      r_oldX     <= '0;
      r_oldValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (draw_req) begin
            r_newX <= pipe_x;
            r_newY <= pipe_y;
            busy   <= 1'b1;
          end
        end
        S_ERASE, S_DRAW: begin
          vga_x  <= w_colSum[7:0];
          vga_y  <= r_row;
          colour <= w_pixColour;
          plot   <= (w_colSum < 9'(SCREEN_W));
        end
        S_DONE: begin
          plot       <= 1'b0;
          done       <= 1'b1;
          busy       <= 1'b0;
          r_oldX     <= r_newX;
          r_oldValid <= 1'b1;
        end
        default: plot <= 1'b0;
      endcase
    end
  end

endmodule
